baseline_a76_fabric: RTL and testbench

Fabric-side control subsystem of the baseline_a76 top level, clocked by the 100 MHz board reference. It sequences the fabric reset release, exporting `sys_clk_100_reset_n`. It synchronizes and debounces the user push buttons and DIP switches. It drives the four user LEDs. HPS, EMIF, USB and other hard-IP pins are owned by the HPS subsystem wrapper and are not part of this block.

---
 rtl/baseline_a76_pkg.sv | 13 +
 rtl/baseline_a76_debounce.sv | 47 ++++
 rtl/baseline_a76_fabric.sv | 123 ++++++++++++
 tb/tb_baseline_a76_fabric.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baseline_a76_pkg.sv
// Shared widths and default parameter values for the baseline_a76 fabric control block.
package baseline_a76_pkg;

    localparam int IO_W                = 4;
    localparam int RST_CNT_W           = 10;

    localparam int DEF_RST_HOLD_CYCLES = 64;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_HEARTBEAT_DIV   = 50_000_000;

    typedef logic [IO_W-1:0] io_t;

endpackage

// File: rtl/baseline_a76_debounce.sv
// One-bit 2-FF synchronizer followed by a stability counter; also flags accepted 0->1 changes.
module baseline_a76_debounce
    import baseline_a76_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic value,
    output logic rise
);

    localparam int              CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The accepted value flips on the cycle the counter is seen at LIMIT with the change still present.
    assign accept = (sync_p1 != value) && (cnt == LIMIT);
    assign rise   = accept && sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            value   <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability filter
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            if (sync_p1 == value) begin
                cnt <= '0;
            end else if (accept) begin
                value <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/baseline_a76_fabric.sv
// Fabric control: reset-release sequencer, debounced switches/buttons and the four user LEDs.
// Optional LED 0 heartbeat is built when BASELINE_A76_HEARTBEAT_EN is defined.
module baseline_a76_fabric
    import baseline_a76_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HEARTBEAT_DIV   = DEF_HEARTBEAT_DIV
) (
    input  logic            pll_refclk_100,
    input  logic            system_reset,
    input  logic            fpga_reset_n,
    input  logic [IO_W-1:0] fpga_user_switches,
    input  logic [IO_W-1:0] fpga_user_push_buttons,
    output logic [IO_W-1:0] fpga_user_leds,
    output logic            sys_clk_100_reset_n
);

    localparam logic [RST_CNT_W-1:0] HOLD = RST_CNT_W'(RST_HOLD_CYCLES);

    logic                 rst_sync_p0;
    logic                 rst_sync_p1;
    logic                 seq_clear;
    logic                 logic_rst;
    logic [RST_CNT_W-1:0] rst_cnt;
    io_t                  sw_value;
    io_t                  sw_rise_unused;
    io_t                  btn_value_unused;
    io_t                  btn_rise;
    io_t                  led_state;
    io_t                  led_next;

    assign seq_clear = system_reset || !rst_sync_p1;
    // Everything downstream of the sequencer stays cleared until the exported reset deasserts.
    assign logic_rst = system_reset || !sys_clk_100_reset_n;

    always_ff @(posedge pll_refclk_100) begin
        if (system_reset) begin
            rst_sync_p0 <= 1'b1;
            rst_sync_p1 <= 1'b1;
        end else begin
            // stage p0 -> p1: board warm-reset synchronizer
            rst_sync_p0 <= fpga_reset_n;
            rst_sync_p1 <= rst_sync_p0;
        end
    end

    always_ff @(posedge pll_refclk_100) begin
        if (seq_clear) begin
            rst_cnt             <= '0;
            sys_clk_100_reset_n <= 1'b0;
        end else begin
            if (rst_cnt != HOLD) begin
                rst_cnt <= rst_cnt + RST_CNT_W'(1);
            end
            sys_clk_100_reset_n <= (rst_cnt == HOLD);
        end
    end

    for (genvar i = 0; i < IO_W; i++) begin : g_inputs
        baseline_a76_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sw (
            .clk  (pll_refclk_100),
            .rst  (logic_rst),
            .din  (fpga_user_switches[i]),
            .value(sw_value[i]),
            .rise (sw_rise_unused[i])
        );

        baseline_a76_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (pll_refclk_100),
            .rst  (logic_rst),
            .din  (fpga_user_push_buttons[i]),
            .value(btn_value_unused[i]),
            .rise (btn_rise[i])
        );
    end

`ifdef BASELINE_A76_HEARTBEAT_EN
    localparam int               HB_W    = $clog2(HEARTBEAT_DIV);
    localparam logic [HB_W-1:0]  HB_LAST = HB_W'(HEARTBEAT_DIV - 1);

    logic [HB_W-1:0] hb_cnt;
    logic            hb_tick;
    logic            unused_led0;

    assign hb_tick     = (hb_cnt == HB_LAST);
    assign unused_led0 = led_state[0] ^ sw_value[0];

    always_ff @(posedge pll_refclk_100) begin
        if (logic_rst || hb_tick) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end
`else
    logic unused_hb_cfg;
    assign unused_hb_cfg = (HEARTBEAT_DIV > 1);
`endif

    always_comb begin
        led_next = led_state ^ sw_value;
`ifdef BASELINE_A76_HEARTBEAT_EN
        led_next[0] = hb_tick ? ~fpga_user_leds[0] : fpga_user_leds[0];
`endif
    end

    always_ff @(posedge pll_refclk_100) begin
        if (logic_rst) begin
            led_state      <= '0;
            fpga_user_leds <= '0;
        end else begin
            // stage: LED output register
            led_state      <= led_state ^ btn_rise;
            fpga_user_leds <= led_next;
        end
    end

endmodule

// File: tb/tb_baseline_a76_fabric.sv
// Self-checking bench for baseline_a76_fabric: directed scenarios plus random input activity
// compared every cycle against a window-based behavioural model.
module tb_baseline_a76_fabric;

    localparam int HOLD = 64;
    localparam int DEB  = 16;
    localparam int HB   = 8;
`ifdef BASELINE_A76_HEARTBEAT_EN
    localparam logic [3:0] CMP_MASK = 4'b1110;
`else
    localparam logic [3:0] CMP_MASK = 4'b1111;
`endif

    logic       clk = 1'b0;
    logic       system_reset = 1'b1;
    logic       fpga_reset_n = 1'b1;
    logic [3:0] sw  = 4'b0000;
    logic [3:0] btn = 4'b0000;
    logic [3:0] leds;
    logic       rstn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    baseline_a76_fabric #(
        .RST_HOLD_CYCLES(HOLD),
        .DEBOUNCE_CYCLES(DEB),
        .HEARTBEAT_DIV  (HB)
    ) dut (
        .pll_refclk_100        (clk),
        .system_reset          (system_reset),
        .fpga_reset_n          (fpga_reset_n),
        .fpga_user_switches    (sw),
        .fpga_user_push_buttons(btn),
        .fpga_user_leds        (leds),
        .sys_clk_100_reset_n   (rstn)
    );

    // Behavioural model: reset output is high once HOLD+1 consecutive edges passed without a
    // clear request; an input bit is accepted once its last DEB+1 raw samples (seen through the
    // two-cycle synchronizer lag) all disagree with the current accepted value.
    logic [1:0] m_fr = 2'b11;
    int         m_clean = 0;
    logic       m_rstn = 1'b0;
    logic [7:0] m_hist[$];
    logic [3:0] m_sw_acc = '0, m_btn_acc = '0, m_led_state = '0, m_leds = '0;

    initial for (int i = 0; i < DEB + 3; i++) m_hist.push_back(8'h00);

    always @(posedge clk) begin : model
        logic       lrst, clear;
        logic [7:0] w_and, w_or, acc_old, acc_new;
        lrst  = system_reset || !m_rstn;
        clear = system_reset || !m_fr[1];
        m_fr  = system_reset ? 2'b11 : {m_fr[0], fpga_reset_n};
        if (clear) m_clean = 0;
        else if (m_clean < HOLD + 1) m_clean = m_clean + 1;
        if (lrst) begin
            m_leds = '0; m_led_state = '0; m_sw_acc = '0; m_btn_acc = '0;
            for (int i = 0; i < DEB + 3; i++) m_hist[i] = 8'h00;
        end else begin
            m_leds = m_led_state ^ m_sw_acc;
            w_and = 8'hff;
            w_or  = 8'h00;
            for (int i = 1; i <= DEB + 1; i++) begin
                w_and = w_and & m_hist[i];
                w_or  = w_or | m_hist[i];
            end
            acc_old = {m_btn_acc, m_sw_acc};
            acc_new = (acc_old | w_and) & w_or;
            m_led_state = m_led_state ^ (acc_new[7:4] & ~acc_old[7:4]);
            {m_btn_acc, m_sw_acc} = acc_new;
            void'(m_hist.pop_front());
            m_hist.push_back({btn, sw});
        end
        m_rstn = (m_clean >= HOLD + 1);
    end

    task automatic test_reset();
        int  n;
        bit  seen;
        system_reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rstn !== 1'b0 || leds !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: rstn=%b leds=%b required rstn=0 leds=0000", rstn, leds);
        end
        system_reset = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 1000) begin
            @(negedge clk);
            n++;
            checks++;
            if (rstn !== m_rstn || (leds & CMP_MASK) !== (m_leds & CMP_MASK)) begin
                errors++;
                $display("FAIL release_model: rstn=%b leds=%b required rstn=%b leds=%b", rstn, leds, m_rstn, m_leds);
            end
            if (rstn === 1'b1) seen = 1;
        end
        checks++;
        if (n !== HOLD + 1) begin
            errors++;
            $display("FAIL release_latency: rose after %0d edges, required %0d", n, HOLD + 1);
        end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if ((leds & CMP_MASK) !== 4'b0000) begin
                errors++;
                $display("FAIL idle_leds: leds=%b required 0000", leds);
            end
        end
    endtask

    task automatic test_switches();
        sw = 4'b1010;
        for (int i = 1; i <= DEB + 4; i++) begin
            @(negedge clk);
            if (i == DEB + 3) begin
                checks++;
                if ((leds & CMP_MASK) !== 4'b0000) begin
                    errors++;
                    $display("FAIL switch_early: leds=%b required 0000 at edge %0d", leds, i);
                end
            end
        end
        checks++;
        if ((leds & CMP_MASK) !== (4'b1010 & CMP_MASK)) begin
            errors++;
            $display("FAIL switch_latency: leds=%b required 1010", leds);
        end
        sw = 4'b0000;
        repeat (DEB + 6) @(negedge clk);
        checks++;
        if ((leds & CMP_MASK) !== 4'b0000) begin
            errors++;
            $display("FAIL switch_release: leds=%b required 0000", leds);
        end
    endtask

    task automatic test_button();
        logic [3:0] want [3] = '{4'b0100, 4'b0000, 4'b0100};
        for (int p = 0; p < 3; p++) begin
            btn[2] = 1'b1;
            for (int i = 1; i <= 30; i++) begin
                @(negedge clk);
                if (i == DEB + 4 || i == 30) begin
                    checks++;
                    if ((leds & CMP_MASK) !== (want[p] & CMP_MASK)) begin
                        errors++;
                        $display("FAIL button_hold: press %0d edge %0d leds=%b required %b", p, i, leds, want[p]);
                    end
                end
            end
            btn[2] = 1'b0;
            repeat (DEB + 6) @(negedge clk);
            checks++;
            if ((leds & CMP_MASK) !== (want[p] & CMP_MASK)) begin
                errors++;
                $display("FAIL button_release: press %0d leds=%b required %b", p, leds, want[p]);
            end
        end
    endtask

    task automatic test_glitch();
        int         len  [4] = '{5, DEB, DEB + 1, DEB + 1};
        logic [3:0] want [4] = '{4'b0100, 4'b0100, 4'b0110, 4'b0100};
        for (int g = 0; g < 4; g++) begin
            btn[1] = 1'b1;
            repeat (len[g]) @(negedge clk);
            btn[1] = 1'b0;
            repeat (DEB + 8) @(negedge clk);
            checks++;
            if ((leds & CMP_MASK) !== (want[g] & CMP_MASK)) begin
                errors++;
                $display("FAIL glitch_%0d: pulse %0d cycles leds=%b required %b", g, len[g], leds, want[g]);
            end
        end
    endtask

    task automatic test_fpga_reset();
        int fall = -1;
        int rise = -1;
        fpga_reset_n = 1'b0;
        for (int i = 1; i <= 200 && rise < 0; i++) begin
            @(negedge clk);
            if (i == 4) fpga_reset_n = 1'b1;
            checks++;
            if (rstn !== m_rstn || (leds & CMP_MASK) !== (m_leds & CMP_MASK)) begin
                errors++;
                $display("FAIL warm_model: edge %0d rstn=%b leds=%b required rstn=%b leds=%b", i, rstn, leds, m_rstn, m_leds);
            end
            if (i == 5) begin
                checks++;
                if (leds !== 4'b0000) begin
                    errors++;
                    $display("FAIL warm_leds: leds=%b required 0000", leds);
                end
            end
            if (fall < 0 && rstn === 1'b0) fall = i;
            if (fall >= 0 && rstn === 1'b1) rise = i;
        end
        checks++;
        if (fall !== 3) begin
            errors++;
            $display("FAIL warm_fall: fell at edge %0d required 3", fall);
        end
        checks++;
        if (rise !== 71) begin
            errors++;
            $display("FAIL warm_rerelease: rose at edge %0d required 71", rise);
        end
    endtask

    task automatic test_midop_reset();
        int n = 0;
        btn[3] = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        btn[3] = 1'b0;
        repeat (DEB + 4) @(negedge clk);
        checks++;
        if ((leds & CMP_MASK) !== (4'b1000 & CMP_MASK)) begin
            errors++;
            $display("FAIL midop_setup: leds=%b required 1000", leds);
        end
        system_reset = 1'b1;
        @(negedge clk);
        system_reset = 1'b0;
        checks++;
        if (leds !== 4'b0000 || rstn !== 1'b0) begin
            errors++;
            $display("FAIL midop_clear: leds=%b rstn=%b required 0000 and 0", leds, rstn);
        end
        while (rstn !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== HOLD + 1 || (leds & CMP_MASK) !== 4'b0000) begin
            errors++;
            $display("FAIL midop_release: edges=%0d leds=%b required %0d and 0000", n, leds, HOLD + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            checks++;
            if (rstn !== m_rstn || (leds & CMP_MASK) !== (m_leds & CMP_MASK)) begin
                errors++;
                $display("FAIL random_model: cycle %0d rstn=%b leds=%b required rstn=%b leds=%b", i, rstn, leds, m_rstn, m_leds);
            end
            if ($urandom_range(0, 11) == 0) sw[$urandom_range(0, 3)] = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) btn[$urandom_range(0, 3)] = $urandom_range(0, 1);
            if (i == 900) fpga_reset_n = 1'b0;
            if (i == 903) fpga_reset_n = 1'b1;
        end
        sw  = '0;
        btn = '0;
        repeat (DEB + 6) @(negedge clk);
    endtask

`ifdef BASELINE_A76_HEARTBEAT_EN
    task automatic test_heartbeat();
        logic prev = leds[0];
        int   last = -1;
        int   toggles = 0;
        for (int i = 1; i <= 6 * HB; i++) begin
            @(negedge clk);
            if (leds[0] !== prev) begin
                toggles++;
                if (last >= 0) begin
                    checks++;
                    if (i - last !== HB) begin
                        errors++;
                        $display("FAIL heartbeat_period: %0d cycles required %0d", i - last, HB);
                    end
                end
                last = i;
                prev = leds[0];
            end
        end
        checks++;
        if (toggles < 5) begin
            errors++;
            $display("FAIL heartbeat_count: %0d toggles required at least 5", toggles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_switches();
        test_button();
        test_glitch();
        test_fpga_reset();
        test_midop_reset();
`ifdef BASELINE_A76_HEARTBEAT_EN
        test_heartbeat();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
